// File: rtl/latch_strobe_tx.sv
// latch_strobe_tx
// Serial transmitter that drives the data/enable pair of a downstream
// level-sensitive D latch. A parallel word is shifted out MSB-first; each bit
// gets one setup cycle (strobe low, data settles) followed by STROBE_CYCLES
// cycles with strobe high while the data is held stable.
//
// Parameters:
//   WIDTH         bits per word (1..16)
//   STROBE_CYCLES cycles the strobe stays high per bit (1..8)
// Ports:
//   c       clock, rising edge
//   rn      asynchronous active-low reset
//   start   request to send word, sampled only in IDLE
//   word    parallel data, captured on the accepting edge
//   dout    serial data to the receiver latch D input
//   strobe  latch enable to the receiver latch C input
//   busy    high while a frame is in progress
//   done    one-cycle pulse after the last strobe of a frame
module latch_strobe_tx #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic             c,
  input  logic             rn,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic             dout,
  output logic             strobe,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [SW-1:0]    stb_cnt, stb_n;
  logic             dout_n, strobe_n, busy_n, done_n;

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      stb_cnt <= '0;
      dout    <= 1'b0;
      strobe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_n;
      stb_cnt <= stb_n;
      dout    <= dout_n;
      strobe  <= strobe_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    stb_n   = stb_cnt;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shift_n = word;
          bit_n   = BW'(WIDTH);
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        stb_n   = SW'(STROBE_CYCLES);
        state_n = ST_STROBE;
      end
      ST_STROBE: begin
        // <= rather than == so a corrupted zero count still terminates
        if (stb_cnt <= SW'(1)) begin
          stb_n = '0;
          if (bit_cnt <= BW'(1)) begin
            state_n = ST_DONE;
          end else begin
            shift_n = shift << 1;
            bit_n   = bit_cnt - BW'(1);
            state_n = ST_SETUP;
          end
        end else begin
          stb_n = stb_cnt - SW'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered: decode them from the next state so the flops
  // present the values belonging to the state being entered.
  always_comb begin
    dout_n   = 1'b0;
    strobe_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    case (state_n)
      ST_SETUP: begin
        dout_n = shift_n[WIDTH-1];
        busy_n = 1'b1;
      end
      ST_STROBE: begin
        dout_n   = shift_n[WIDTH-1];
        strobe_n = 1'b1;
        busy_n   = 1'b1;
      end
      ST_DONE: begin
        busy_n = 1'b1;
        done_n = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
